// File: rtl/core_pkg.sv
// Shared core constants and the register-file sequencer state type.
package core_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage : core_pkg

// File: rtl/reg_file_sb_if.sv
// Issue, write-back and read-port bundle between decode/write-back and the register file.
interface reg_file_sb_if
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned AW   = $clog2(NREGS_DEF)
);

  logic            ready;
  logic [AW-1:0]   rs1_addr;
  logic [XLEN-1:0] rs1_data;
  logic            rs1_busy;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs2_data;
  logic            rs2_busy;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  modport master (
    input  ready, rs1_data, rs1_busy, rs2_data, rs2_busy,
    output rs1_addr, rs2_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data
  );

  modport slave (
    output ready, rs1_data, rs1_busy, rs2_data, rs2_busy,
    input  rs1_addr, rs2_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data
  );

endinterface : reg_file_sb_if

// File: rtl/reg_scoreboard.sv
// Per-register pending bits: clear on write-back, set on issue (set wins), flush clears all.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic [AW-1:0] rd1_idx_i,
  input  logic [AW-1:0] rd2_idx_i,
  output logic          rd1_pend_o,
  output logic          rd2_pend_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rd1_pend_o = pend_q[rd1_idx_i];
  assign rd2_pend_o = pend_q[rd2_idx_i];

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Integer register file with init sweep, optional write-to-read bypass and RAW scoreboard.
module reg_file_sb
  import core_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     NREGS     = NREGS_DEF,
  parameter int unsigned     AW        = $clog2(NREGS),
  parameter logic [XLEN-1:0] RESET_VAL = '0,
  parameter bit              BYPASS    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  reg_file_sb_if.slave     bus
);

  rf_state_t       state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            ready_q, ready_d;
  logic [XLEN-1:0] regs_q [NREGS];

  logic            run;
  logic            hit1, hit2;
  logic            pend1, pend2;

  assign run = (state_q == RF_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      idx_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    unique case (state_q)
      RF_INIT: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end
      end
      RF_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = RF_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // Sweep and write-back share the array write port; INIT locks out write-back.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_INIT) begin
        regs_q[idx_q] <= RESET_VAL;
      end else if (bus.wb_en && (bus.wb_addr != '0)) begin
        regs_q[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .set_en_i   (run && bus.iss_valid && (bus.iss_rd != '0)),
    .set_idx_i  (bus.iss_rd),
    .clr_en_i   (run && bus.wb_en),
    .clr_idx_i  (bus.wb_addr),
    .rd1_idx_i  (bus.rs1_addr),
    .rd2_idx_i  (bus.rs2_addr),
    .rd1_pend_o (pend1),
    .rd2_pend_o (pend2)
  );

  assign hit1 = BYPASS && bus.wb_en && (bus.wb_addr == bus.rs1_addr);
  assign hit2 = BYPASS && bus.wb_en && (bus.wb_addr == bus.rs2_addr);

  always_comb begin
    bus.rs1_data = '0;
    bus.rs1_busy = 1'b1;
    if (run) begin
      if (bus.rs1_addr == '0) bus.rs1_data = '0;
      else if (hit1)          bus.rs1_data = bus.wb_data;
      else                    bus.rs1_data = regs_q[bus.rs1_addr];
      bus.rs1_busy = pend1 && !hit1;
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    bus.rs2_busy = 1'b1;
    if (run) begin
      if (bus.rs2_addr == '0) bus.rs2_data = '0;
      else if (hit2)          bus.rs2_data = bus.wb_data;
      else                    bus.rs2_data = regs_q[bus.rs2_addr];
      bus.rs2_busy = pend2 && !hit2;
    end
  end

  assign bus.ready = ready_q;

endmodule : reg_file_sb

// File: tb/tb_reg_file_sb.sv
// Directed bench: one bypassing instance (RESET_VAL 0) and one non-bypassing (RESET_VAL A5A5).
module tb_reg_file_sb;

  localparam int unsigned     XLEN = 32;
  localparam int unsigned     AW   = 5;
  localparam logic [XLEN-1:0] RV0  = 32'h0000_0000;
  localparam logic [XLEN-1:0] RV1  = 32'h0000_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN), .AW(AW)) bus0 ();
  reg_file_sb_if #(.XLEN(XLEN), .AW(AW)) bus1 ();

  reg_file_sb #(.XLEN(XLEN), .NREGS(32), .RESET_VAL(RV0), .BYPASS(1'b1)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave)
  );
  reg_file_sb #(.XLEN(XLEN), .NREGS(32), .RESET_VAL(RV1), .BYPASS(1'b0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    bus0.rs1_addr = a1; bus1.rs1_addr = a1;
    bus0.rs2_addr = a2; bus1.rs2_addr = a2;
  endtask

  task automatic set_wb(input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus0.wb_en = en; bus1.wb_en = en;
    bus0.wb_addr = a; bus1.wb_addr = a;
    bus0.wb_data = d; bus1.wb_data = d;
  endtask

  task automatic set_iss(input logic v, input logic [AW-1:0] rd);
    bus0.iss_valid = v; bus1.iss_valid = v;
    bus0.iss_rd = rd;   bus1.iss_rd = rd;
  endtask

  // Counts cycles until ready with reads checked as 0/busy during the sweep.
  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!bus0.ready && n < 40) begin
      set_rd(5'(n), 5'(31 - n));
      #1;
      checks++;
      if (bus0.rs1_data !== '0 || bus1.rs2_data !== '0 || bus0.rs1_busy !== 1'b1 || bus1.rs2_busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_init_read n=%0d: d0=%h d1=%h b0=%b b1=%b required 0/0/1/1",
                 tag, n, bus0.rs1_data, bus1.rs2_data, bus0.rs1_busy, bus1.rs2_busy);
      end
      step();
      n++;
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(i));
      #1;
      checks++;
      if (bus0.rs1_data !== ((i == 0) ? 32'h0 : RV0) || bus1.rs2_data !== ((i == 0) ? 32'h0 : RV1)) begin
        errors++;
        $display("FAIL %s_regval r%0d: d0=%h d1=%h required %h %h", tag, i,
                 bus0.rs1_data, bus1.rs2_data, (i == 0) ? 32'h0 : RV0, (i == 0) ? 32'h0 : RV1);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus0.ready !== 1'b0 || bus1.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b %b required 0", bus0.ready, bus1.ready);
    end
    rst = 1'b0;
    wait_ready("reset", n);
    checks++;
    if (n != 31 || bus1.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep_len: got %0d cycles (ready1=%b) required 31", n, bus1.ready);
    end
    check_all_regs("reset");
  endtask

  task automatic test_write();
    set_rd(5'd5, 5'd5);
    set_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (bus0.rs1_data !== 32'hDEAD_BEEF || bus1.rs1_data !== RV1) begin
      errors++;
      $display("FAIL write_same_cycle: d0=%h d1=%h required DEADBEEF %h", bus0.rs1_data, bus1.rs1_data, RV1);
    end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus0.rs1_data !== 32'hDEAD_BEEF || bus1.rs1_data !== 32'hDEAD_BEEF ||
        bus0.rs2_data !== 32'hDEAD_BEEF || bus1.rs2_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_next_cycle: d0=%h/%h d1=%h/%h required DEADBEEF", bus0.rs1_data,
               bus0.rs2_data, bus1.rs1_data, bus1.rs2_data);
    end
  endtask

  task automatic test_x0();
    set_rd(5'd0, 5'd0);
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_iss(1'b1, 5'd0);
    #1;
    checks++;
    if (bus0.rs1_data !== 32'h0 || bus1.rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_same_cycle: d0=%h d1=%h required 0", bus0.rs1_data, bus1.rs1_data);
    end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    set_iss(1'b0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus0.rs1_data !== 32'h0 || bus1.rs1_data !== 32'h0 || bus0.rs1_busy !== 1'b0 || bus1.rs1_busy !== 1'b0) begin
        errors++;
        $display("FAIL x0_after c=%0d: d=%h %h busy=%b %b required 0", c, bus0.rs1_data,
                 bus1.rs1_data, bus0.rs1_busy, bus1.rs1_busy);
      end
      step();
    end
  endtask

  task automatic test_scoreboard();
    set_rd(5'd12, 5'd7);
    set_iss(1'b1, 5'd7);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b0 || bus1.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_before_issue: busy=%b %b required 0", bus0.rs2_busy, bus1.rs2_busy);
    end
    step();
    set_iss(1'b0, 5'd0);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b1 || bus1.rs2_busy !== 1'b1 || bus0.rs1_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_after_issue: r7 busy=%b %b r12 busy=%b required 1 1 0", bus0.rs2_busy,
               bus1.rs2_busy, bus0.rs1_busy);
    end
    set_wb(1'b1, 5'd7, 32'h0000_0123);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b0 || bus1.rs2_busy !== 1'b1 || bus0.rs2_data !== 32'h123) begin
      errors++;
      $display("FAIL sb_wb_same_cycle: busy=%b %b d0=%h required 0 1 00000123", bus0.rs2_busy,
               bus1.rs2_busy, bus0.rs2_data);
    end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b0 || bus1.rs2_busy !== 1'b0 || bus1.rs2_data !== 32'h123) begin
      errors++;
      $display("FAIL sb_wb_after: busy=%b %b d1=%h required 0 0 00000123", bus0.rs2_busy,
               bus1.rs2_busy, bus1.rs2_data);
    end
    set_iss(1'b1, 5'd7);
    step();
    set_wb(1'b1, 5'd7, 32'h0000_0456);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b0 || bus1.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_clr_same_cycle: busy=%b %b required 0 1", bus0.rs2_busy, bus1.rs2_busy);
    end
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    set_iss(1'b0, 5'd0);
    #1;
    checks++;
    if (bus0.rs2_busy !== 1'b1 || bus1.rs2_busy !== 1'b1 || bus1.rs2_data !== 32'h456) begin
      errors++;
      $display("FAIL sb_set_wins: busy=%b %b d1=%h required 1 1 00000456", bus0.rs2_busy,
               bus1.rs2_busy, bus1.rs2_data);
    end
    set_wb(1'b1, 5'd12, 32'h0000_0077);
    step();
    set_wb(1'b0, 5'd0, 32'h0);
    #1;
    checks++;
    if (bus0.rs1_busy !== 1'b0 || bus1.rs1_busy !== 1'b0 || bus1.rs1_data !== 32'h77 || bus0.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL sb_wb_not_pending: r12 busy=%b %b d1=%h r7 busy=%b required 0 0 00000077 1",
               bus0.rs1_busy, bus1.rs1_busy, bus1.rs1_data, bus0.rs2_busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_iss(1'b1, 5'd3);
    step();
    set_iss(1'b1, 5'd9);
    step();
    set_iss(1'b0, 5'd0);
    set_rd(5'd3, 5'd9);
    #1;
    checks++;
    if (bus0.rs1_busy !== 1'b1 || bus0.rs2_busy !== 1'b1 || bus1.rs1_busy !== 1'b1 || bus1.rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pending_set: busy=%b%b %b%b required 11 11", bus0.rs1_busy,
               bus0.rs2_busy, bus1.rs1_busy, bus1.rs2_busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("mid", n);
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL mid_sweep_len: got %0d cycles required 31", n);
    end
    set_rd(5'd3, 5'd9);
    #1;
    checks++;
    if (bus0.rs1_busy !== 1'b0 || bus0.rs2_busy !== 1'b0 || bus1.rs1_busy !== 1'b0 || bus1.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_pending_cleared: busy=%b%b %b%b required 00 00", bus0.rs1_busy,
               bus0.rs2_busy, bus1.rs1_busy, bus1.rs2_busy);
    end
    check_all_regs("mid");
  endtask

  task automatic test_init_lockout();
    int n;
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_wb(1'b1, 5'd4, 32'h0000_0055);
    set_iss(1'b1, 5'd4);
    n = 0;
    while (!bus0.ready && n < 40) begin
      step();
      n++;
    end
    set_wb(1'b0, 5'd0, 32'h0);
    set_iss(1'b0, 5'd0);
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL lockout_sweep_len: got %0d cycles required 31", n);
    end
    set_rd(5'd4, 5'd4);
    #1;
    checks++;
    if (bus0.rs1_data !== RV0 || bus1.rs1_data !== RV1 || bus0.rs2_busy !== 1'b0 || bus1.rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL lockout_r4: d=%h %h busy=%b %b required %h %h 0 0", bus0.rs1_data,
               bus1.rs1_data, bus0.rs2_busy, bus1.rs2_busy, RV0, RV1);
    end
  endtask

  initial begin
    set_rd(5'd0, 5'd0);
    set_wb(1'b0, 5'd0, 32'h0);
    set_iss(1'b0, 5'd0);
    test_reset();
    test_write();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    test_init_lockout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_sb
